// File: rtl/mem_port.sv
// mem_port: datapath-side responder for the memory control lines of the
// multi-cycle control unit. Holds MAR/MDR, owns a word-addressed RAM with a
// fixed access latency, and reports busy/done/error status.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   bus_in          value currently on the internal bus
//   bus_out         value driven onto the bus (0 when not driving)
//   bus_drive       bus_out is valid and must be muxed onto the bus
//   MARBusMode      00/11 hold, 01 load MAR from bus, 10 drive MAR to bus
//   MDRBusMode      same encoding, applied to MDR
//   MDRMemMode      01 MDR captures read data, 10 MDR is write-data source
//   MemMode         01 read, 10 write, 00/11 idle
//   mem_busy        access in progress
//   mem_done        one-cycle pulse when an access completes
//   mem_err         sticky error flag, cleared only by reset
//
// Build option: define MEMPORT_BOUNDS_EN to flag accesses whose MAR has bits
// set above ADDR_BITS; such accesses still take LATENCY cycles, read 0 and
// never write. Without it the upper MAR bits are silently truncated.
//
// state  | meaning
// S_IDLE | waiting for a read/write request
// S_BUSY | access in flight, counter running down to 0
// S_DONE | completion pulse; requests are not accepted here
module mem_port #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2    // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  input  logic [1:0]       MARBusMode,
  input  logic [1:0]       MDRBusMode,
  input  logic [1:0]       MDRMemMode,
  input  logic [1:0]       MemMode,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 accept, complete;
  logic [WIDTH-1:0]     mar, mdr;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 op_wr_q;
  logic [1:0]           mm_q;
  logic                 oor_q, oor_now;
  logic                 rd_ok, wr_ok, acc_err, conflict;

  logic [WIDTH-1:0] ram [0:(1 << ADDR_BITS) - 1];

`ifdef MEMPORT_BOUNDS_EN
  assign oor_now = |mar[WIDTH-1:ADDR_BITS];
`else
  assign oor_now = 1'b0;
`endif

  // Completion decisions use only the snapshot taken at accept, so bus
  // traffic on MAR during the access cannot redirect it.
  assign rd_ok    = !op_wr_q && !oor_q && (mm_q == 2'b01);
  assign wr_ok    =  op_wr_q && !oor_q && (mm_q == 2'b10);
  assign acc_err  = !(rd_ok || wr_ok);
  assign conflict = (MARBusMode == 2'b10) && (MDRBusMode == 2'b10);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    complete  = 1'b0;
    mem_busy  = 1'b0;
    mem_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (MemMode == 2'b01 || MemMode == 2'b10) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        mem_busy = 1'b1;
        if (cnt == 4'd0) begin
          complete  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        mem_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar     <= '0;
      mdr     <= '0;
      mem_err <= 1'b0;
      addr_q  <= '0;
      op_wr_q <= 1'b0;
      mm_q    <= 2'b00;
      oor_q   <= 1'b0;
    end else begin
      if (MARBusMode == 2'b01)
        mar <= bus_in;
      // MDR belongs to the access while busy; bus loads are dropped then.
      if (MDRBusMode == 2'b01 && state != S_BUSY)
        mdr <= bus_in;
      if (accept) begin
        addr_q  <= mar[ADDR_BITS-1:0];
        op_wr_q <= (MemMode == 2'b10);
        mm_q    <= MDRMemMode;
        oor_q   <= oor_now;
      end
      if (complete && !op_wr_q) begin
        if (oor_q)
          mdr <= '0;
        else if (rd_ok)
          mdr <= ram[addr_q];
      end
      if ((complete && acc_err) || conflict)
        mem_err <= 1'b1;
    end
  end

  // RAM is never reset; a reset landing on the completion edge cancels the write.
  always_ff @(posedge clk) begin
    if (!reset && complete && wr_ok)
      ram[addr_q] <= mdr;
  end

  always_comb begin
    bus_out   = '0;
    bus_drive = 1'b0;
    if (MDRBusMode == 2'b10) begin
      bus_out   = mdr;
      bus_drive = 1'b1;
    end else if (MARBusMode == 2'b10) begin
      bus_out   = mar;
      bus_drive = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port.sv
module tb_mem_port;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic [1:0]  mar_m, mdr_m, mdrmem_m, mem_m;
  logic [15:0] bus_out;
  logic        bus_drive, mem_busy, mem_done, mem_err;

  always #5 clk = ~clk;

  mem_port #(.WIDTH(16), .ADDR_BITS(12), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out),
    .bus_drive(bus_drive), .MARBusMode(mar_m), .MDRBusMode(mdr_m),
    .MDRMemMode(mdrmem_m), .MemMode(mem_m), .mem_busy(mem_busy),
    .mem_done(mem_done), .mem_err(mem_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  done_t       done_q[$];
  logic [15:0] bus_q[$];

  // Reference model: architectural view of MAR, MDR, RAM and the error flag.
  logic [15:0] m_mar, m_mdr;
  logic        m_err;
  logic [15:0] m_ram [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT drives the bus or completes.
  int busy_run = 0;
  always @(negedge clk) begin
    if (reset === 1'b1) busy_run = 0;
    else if (mem_busy === 1'b1) busy_run++;
    if (bus_drive === 1'b1) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_drive: got bus_out %0h, expected no drive", bus_out);
      end else begin
        logic [15:0] e;
        e = bus_q.pop_front();
        chk("bus_out", bus_out, e);
      end
    end
    if (mem_done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got mem_done at cycle %0d, expected none", cyc);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_err", mem_err, d.err);
        chk("busy_len", busy_run, LAT);
        chk("busy_at_done", mem_busy, 0);
      end
      busy_run = 0;
    end
  end

  task automatic step(input logic [1:0] ma, input logic [1:0] md, input logic [1:0] mm,
                      input logic [1:0] me, input logic [15:0] bi, input logic rst);
    mar_m = ma; mdr_m = md; mdrmem_m = mm; mem_m = me; bus_in = bi; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 2'b00, 2'b00, 16'h0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(2'b01, 2'b01, 2'b01, 2'b01, 16'hFFFF, 1'b1);
    m_mar = 16'h0; m_mdr = 16'h0; m_err = 1'b0;
  endtask

  task automatic load_mar(input logic [15:0] v);
    step(2'b01, 2'b00, 2'b00, 2'b00, v, 1'b0);
    m_mar = v;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    step(2'b00, 2'b01, 2'b00, 2'b00, v, 1'b0);
    m_mdr = v;
  endtask

  task automatic drive_mar();
    bus_q.push_back(m_mar);
    step(2'b10, 2'b00, 2'b00, 2'b00, 16'h0, 1'b0);
  endtask

  task automatic drive_mdr();
    bus_q.push_back(m_mdr);
    step(2'b00, 2'b10, 2'b00, 2'b00, 16'h0, 1'b0);
  endtask

  function automatic logic out_of_range(input logic [15:0] a);
`ifdef MEMPORT_BOUNDS_EN
    return a[15:12] != 4'h0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete access. The model applies its final effect at issue; the
  // DUT's outcome is only observed after completion. With disturb set, the
  // first busy cycle carries an MAR+MDR bus load of dv and a write request.
  task automatic access(input logic wr, input logic [1:0] mm, input logic disturb,
                        input logic [15:0] dv);
    logic o;
    int   a;
    o = out_of_range(m_mar);
    a = int'(m_mar[11:0]);
    if (wr) begin
      if (mm == 2'b10 && !o) m_ram[a] = m_mdr;
      else m_err = 1'b1;
    end else begin
      if (o) begin m_mdr = 16'h0; m_err = 1'b1; end
      else if (mm == 2'b01) m_mdr = m_ram[a];
      else m_err = 1'b1;
    end
    done_q.push_back('{cyc + 1 + LAT, m_err});
    step(2'b00, 2'b00, mm, wr ? 2'b10 : 2'b01, 16'h0, 1'b0);
    for (int i = 0; i < LAT; i++) begin
      if (disturb && i == 0) begin
        step(2'b01, 2'b01, 2'b10, 2'b10, dv, 1'b0);
        m_mar = dv;
      end else begin
        idle();
      end
    end
    idle();
  endtask

  logic [11:0] pool [6];

  initial begin
    mar_m = 2'b01; mdr_m = 2'b01; mdrmem_m = 2'b01; mem_m = 2'b01;
    bus_in = 16'hFFFF; reset = 1'b1;
    m_mar = 16'h0; m_mdr = 16'h0; m_err = 1'b0;

    // Reset with every mode active
    do_reset(2);
    chk("rst_busy", mem_busy, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_drive", bus_drive, 0);
    chk("rst_bus_out", bus_out, 0);
    drive_mar();
    drive_mdr();

    // Write/read round trip
    load_mar(16'h0010);
    load_mdr(16'hBEEF);
    access(1'b1, 2'b10, 1'b0, 16'h0);
    load_mdr(16'h0000);
    access(1'b0, 2'b01, 1'b0, 16'h0);
    drive_mdr();

    // Busy-window protection
    load_mar(16'h0020);
    load_mdr(16'h2222);
    access(1'b1, 2'b10, 1'b0, 16'h0);
    load_mar(16'h0010);
    load_mdr(16'h0000);
    access(1'b0, 2'b01, 1'b1, 16'h0020);
    drive_mdr();
    drive_mar();
    access(1'b0, 2'b01, 1'b0, 16'h0);
    drive_mdr();

    // Randomized traffic over a small address pool
    for (int i = 0; i < 6; i++) begin
      pool[i] = 12'($urandom_range(0, 4095));
      load_mar({4'h0, pool[i]});
      load_mdr(16'($urandom));
      access(1'b1, 2'b10, 1'b0, 16'h0);
    end
    for (int n = 0; n < 30; n++) begin
      logic [3:0] up;
      int         idx;
      idx = int'($urandom_range(0, 5));
      up  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      load_mar({up, pool[idx]});
      if ($urandom_range(0, 1) == 1) begin
        load_mdr(16'($urandom));
        access(1'b1, 2'b10, 1'b0, 16'h0);
      end else begin
        access(1'b0, 2'b01, 1'b0, 16'h0);
        drive_mdr();
      end
    end

    // Address wrap / bounds
    load_mar(16'h1010);
    load_mdr(16'hAAAA);
    access(1'b1, 2'b10, 1'b0, 16'h0);
    load_mar(16'h0010);
    load_mdr(16'h0000);
    access(1'b0, 2'b01, 1'b0, 16'h0);
    drive_mdr();
    load_mar(16'h1010);
    access(1'b0, 2'b01, 1'b0, 16'h0);
    drive_mdr();

    // Reset in the middle of a write
    do_reset(1);
    load_mar(16'h0030);
    load_mdr(16'h1111);
    access(1'b1, 2'b10, 1'b0, 16'h0);
    load_mdr(16'h5555);
    step(2'b00, 2'b00, 2'b10, 2'b10, 16'h0, 1'b0);
    do_reset(1);
    chk("abort_busy", mem_busy, 0);
    chk("abort_done", mem_done, 0);
    drive_mdr();
    load_mar(16'h0030);
    access(1'b0, 2'b01, 1'b0, 16'h0);
    drive_mdr();

    // Mismatched read: MDR keeps its value, error sticks
    load_mdr(16'h7777);
    access(1'b0, 2'b00, 1'b0, 16'h0);
    drive_mdr();
    chk("err_sticky", mem_err, m_err);

    // Bus drive conflict from a clean reset
    do_reset(1);
    chk("err_cleared", mem_err, 0);
    load_mar(16'h0ABC);
    load_mdr(16'h5A5A);
    chk("err_before_conflict", mem_err, 0);
    bus_q.push_back(m_mdr);
    step(2'b10, 2'b10, 2'b00, 2'b00, 16'h0, 1'b0);
    m_err = 1'b1;
    chk("err_after_conflict", mem_err, m_err);
    idle();
    idle();

    checks++;
    if (bus_q.size() != 0) begin
      errors++;
      $display("FAIL bus_leftover: got %0d undriven expectations, expected 0", bus_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_leftover: got %0d missing completions, expected 0", done_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
